// File: rtl/jtframe_sdram64_rdslot.sv
// Read-only SDRAM client slot: two-line burst cache in front of one bank port
// of the 64-bit-burst controller, refilled through the rd/ack/dst/dok/rdy handshake.
module jtframe_sdram64_rdslot #(
   parameter int AW    = 22,
   parameter int BURST = 4,
   parameter int DW    = 16
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cs,
   input  logic [AW-1:0] addr,
   input  logic          flush,
   output logic          data_ok,
   output logic [DW-1:0] dout,
   output logic [AW-1:0] sdram_addr,
   output logic          sdram_rd,
   input  logic          sdram_ack,
   input  logic          sdram_dst,
   input  logic          sdram_dok,
   input  logic          sdram_rdy,
   input  logic [15:0]   sdram_din
);
   localparam int OW = $clog2(BURST);
   localparam int IW = (OW == 0) ? 1 : OW;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_FILL} state_t;

   state_t        st;
   logic [1:0]    valid;
   logic          vic;
   logic          flushed;
   logic [IW-1:0] cnt;
   logic [AW-1:0] tag [2];
   logic [AW-1:0] fill_tag;
   logic [15:0]   mem [2][BURST];

   logic [AW-1:0] tag_in;
   logic          hit0, hit1, hit, hsel;
   logic [IW-1:0] idx, k;
   logic [31:0]   rdw;
   logic          dok_fill, last;

   // Lookup: tag compare against both lines and word selection
   always_comb begin
      tag_in    = addr >> OW;
      hit0      = valid[0] && (tag[0] == tag_in);
      hit1      = valid[1] && (tag[1] == tag_in);
      hit       = hit0 | hit1;
      hsel      = !hit0;
      idx       = (OW == 0) ? '0 : IW'(addr);
      k         = idx;
      if (DW == 32) k[0] = 1'b0;
      rdw[15:0]  = mem[hsel][k];
      rdw[31:16] = (DW == 32) ? mem[hsel][k | IW'(1)] : 16'd0;
   end

   // A dok seen in WAIT counts as the first word of the burst
   assign dok_fill = ((st == ST_WAIT) || (st == ST_FILL)) && sdram_dok;
   assign last     = dok_fill && sdram_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st         <= ST_IDLE;
         data_ok    <= 1'b0;
         dout       <= '0;
         sdram_rd   <= 1'b0;
         sdram_addr <= '0;
         valid      <= 2'b00;
         vic        <= 1'b0;
         flushed    <= 1'b0;
         cnt        <= '0;
      end else begin
         data_ok <= cs && hit && !flush;
         if (cs && hit && !flush) dout <= rdw[DW-1:0];
         case (st)
            ST_IDLE: if (cs && !hit) begin
               sdram_addr <= tag_in << OW;
               sdram_rd   <= 1'b1;
               valid[vic] <= 1'b0;
               flushed    <= 1'b0;
               cnt        <= '0;
               st         <= ST_REQ;
            end
            ST_REQ: if (sdram_ack) begin
               sdram_rd <= 1'b0;
               st       <= ST_WAIT;
            end
            ST_WAIT: if (sdram_dst || sdram_dok) st <= ST_FILL;
            default: ;
         endcase
         if (dok_fill && (cnt != IW'(BURST-1))) cnt <= cnt + 1'b1;
         if (last) begin
            if (!flushed) valid[vic] <= 1'b1;
            vic <= ~vic;
            st  <= ST_IDLE;
         end
         // Flush overrides any valid set in the same cycle
         if (flush) begin
            valid <= 2'b00;
            if (st != ST_IDLE) flushed <= 1'b1;
         end
      end
   end

   // Line storage carries no reset; the valid bits guard it
   always_ff @(posedge clk) begin
      if (st == ST_IDLE && cs && !hit) fill_tag <= tag_in;
      if (last) tag[vic] <= fill_tag;
      if (dok_fill) mem[vic][cnt] <= sdram_din;
   end

endmodule

// File: tb/tb_jtframe_sdram64_rdslot.sv
// Bench for jtframe_sdram64_rdslot: DW=16 and DW=32 instances share one
// controller model; expected read data is queued as requests are issued.
module tb_jtframe_sdram64_rdslot;
   logic        clk, rst_n, cs, flush;
   logic [21:0] addr;
   logic        ack, dst, dok, rdy;
   logic [15:0] din;
   logic        data_ok, sdram_rd;
   logic [15:0] dout;
   logic [21:0] sdram_addr;
   logic        data_ok2, sdram_rd2;
   logic [31:0] dout2;
   logic [21:0] sdram_addr2;

   int checks = 0;
   int failures = 0;
   logic [15:0] exp_q[$];

   jtframe_sdram64_rdslot #(.AW(22), .BURST(4), .DW(16)) dut (
      .clk(clk), .rst_n(rst_n), .cs(cs), .addr(addr), .flush(flush),
      .data_ok(data_ok), .dout(dout), .sdram_addr(sdram_addr), .sdram_rd(sdram_rd),
      .sdram_ack(ack), .sdram_dst(dst), .sdram_dok(dok), .sdram_rdy(rdy), .sdram_din(din)
   );

   jtframe_sdram64_rdslot #(.AW(22), .BURST(4), .DW(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .cs(cs), .addr(addr), .flush(flush),
      .data_ok(data_ok2), .dout(dout2), .sdram_addr(sdram_addr2), .sdram_rd(sdram_rd2),
      .sdram_ack(ack), .sdram_dst(dst), .sdram_dok(dok), .sdram_rdy(rdy), .sdram_din(din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Controller model: waits for rd, acks, dst, four doks (optional flush gap before word flush_slot)
   task automatic serve(input logic [3:0][15:0] w, input int ack_dly, input int flush_slot,
                        output bit seen, output logic rd_after_ack, output logic [21:0] req_addr);
      seen = 0;
      rd_after_ack = 1'bx;
      req_addr = 'x;
      for (int i = 0; i < 20; i++) begin
         if (sdram_rd) begin seen = 1; break; end
         tick();
      end
      if (!seen) return;
      req_addr = sdram_addr;
      repeat (ack_dly) tick();
      ack = 1; tick(); ack = 0;
      rd_after_ack = sdram_rd;
      dst = 1; tick(); dst = 0;
      for (int j = 0; j < 4; j++) begin
         if (flush_slot == j) begin flush = 1; tick(); flush = 0; end
         dok = 1; din = w[j]; rdy = (j == 3); tick();
      end
      dok = 0; rdy = 0; din = 16'h0;
   endtask

   task automatic test_reset();
      rst_n = 0; cs = 0; addr = 0; flush = 0; ack = 0; dst = 0; dok = 0; rdy = 0; din = 0;
      tick(); tick();
      checks++; if (data_ok !== 1'b0) begin failures++; $display("FAIL reset_data_ok got=%b exp=0", data_ok); end
      checks++; if (dout !== 16'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0000", dout); end
      checks++; if (sdram_rd !== 1'b0) begin failures++; $display("FAIL reset_rd got=%b exp=0", sdram_rd); end
      checks++; if (sdram_addr !== 22'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", sdram_addr); end
      checks++; if (dout2 !== 32'h0) begin failures++; $display("FAIL reset_dout32 got=%h exp=0", dout2); end
      rst_n = 1;
      tick();
   endtask

   task automatic test_cold_miss();
      bit seen; logic rda; logic [21:0] ra; logic [15:0] e;
      cs = 1; addr = 22'h1235;
      exp_q.push_back(16'hA1);
      serve({16'hA3, 16'hA2, 16'hA1, 16'hA0}, 2, -1, seen, rda, ra);
      checks++; if (!seen) begin failures++; $display("FAIL cold_rd_seen got=0 exp=1"); end
      checks++; if (ra !== 22'h1234) begin failures++; $display("FAIL cold_sdram_addr got=%h exp=001234", ra); end
      checks++; if (rda !== 1'b0) begin failures++; $display("FAIL cold_rd_after_ack got=%b exp=0", rda); end
      checks++; if (data_ok !== 1'b0) begin failures++; $display("FAIL cold_data_ok_early got=%b exp=0", data_ok); end
      tick();
      e = exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
      checks++; if (data_ok !== 1'b1) begin failures++; $display("FAIL cold_data_ok got=%b exp=1", data_ok); end
      checks++; if (dout !== e) begin failures++; $display("FAIL cold_dout got=%h exp=%h", dout, e); end
   endtask

   task automatic test_hits();
      logic [15:0] e; logic [31:0] e2; int k;
      for (int a = 0; a < 4; a++) begin
         addr = 22'h1234 + 22'(a);
         exp_q.push_back(16'hA0 + 16'(a));
         k = a & 2;
         e2 = {16'hA0 + 16'(k + 1), 16'hA0 + 16'(k)};
         tick();
         e = exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
         checks++; if (data_ok !== 1'b1) begin failures++; $display("FAIL hit_data_ok[%0d] got=%b exp=1", a, data_ok); end
         checks++; if (dout !== e) begin failures++; $display("FAIL hit_dout[%0d] got=%h exp=%h", a, dout, e); end
         checks++; if (sdram_rd !== 1'b0) begin failures++; $display("FAIL hit_rd[%0d] got=%b exp=0", a, sdram_rd); end
         checks++; if (dout2 !== e2) begin failures++; $display("FAIL hit_dout32[%0d] got=%h exp=%h", a, dout2, e2); end
      end
   endtask

   task automatic test_victim();
      bit seen; logic rda; logic [21:0] ra; logic [15:0] e;
      addr = 22'h2000;
      serve({16'hB3, 16'hB2, 16'hB1, 16'hB0}, 1, -1, seen, rda, ra);
      checks++; if (ra !== 22'h2000) begin failures++; $display("FAIL vic_addr2000 got=%h exp=002000", ra); end
      addr = 22'h3001;
      serve({16'hC3, 16'hC2, 16'hC1, 16'hC0}, 0, -1, seen, rda, ra);
      checks++; if (ra !== 22'h3000) begin failures++; $display("FAIL vic_addr3000 got=%h exp=003000", ra); end
      tick();
      addr = 22'h2002;
      exp_q.push_back(16'hB2);
      tick();
      e = exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
      checks++; if (data_ok !== 1'b1 || dout !== e) begin failures++; $display("FAIL vic_hit2000 ok=%b got=%h exp=%h", data_ok, dout, e); end
      addr = 22'h1234;
      tick();
      checks++; if (data_ok !== 1'b0) begin failures++; $display("FAIL vic_miss1234_ok got=%b exp=0", data_ok); end
      checks++; if (sdram_rd !== 1'b1) begin failures++; $display("FAIL vic_miss1234_rd got=%b exp=1", sdram_rd); end
      exp_q.push_back(16'hD0);
      serve({16'hD3, 16'hD2, 16'hD1, 16'hD0}, 0, -1, seen, rda, ra);
      tick();
      e = exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
      checks++; if (data_ok !== 1'b1 || dout !== e) begin failures++; $display("FAIL vic_refill ok=%b got=%h exp=%h", data_ok, dout, e); end
   endtask

   task automatic test_dw32();
      bit seen; logic rda; logic [21:0] ra; logic [15:0] e;
      addr = 22'h40;
      serve({16'h4444, 16'h3333, 16'h2222, 16'h1111}, 1, -1, seen, rda, ra);
      addr = 22'h42;
      exp_q.push_back(16'h3333);
      tick();
      e = exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
      checks++; if (data_ok2 !== 1'b1) begin failures++; $display("FAIL dw32_ok got=%b exp=1", data_ok2); end
      checks++; if (dout2 !== 32'h44443333) begin failures++; $display("FAIL dw32_dout got=%h exp=44443333", dout2); end
      checks++; if (dout !== e) begin failures++; $display("FAIL dw16_dout42 got=%h exp=%h", dout, e); end
      addr = 22'h41;
      tick();
      checks++; if (dout2 !== 32'h22221111) begin failures++; $display("FAIL dw32_bit0 got=%h exp=22221111", dout2); end
   endtask

   task automatic test_flush_fill();
      bit seen; logic rda; logic [21:0] ra; logic [15:0] e;
      addr = 22'h5001;
      serve({16'hE3, 16'hE2, 16'hE1, 16'hE0}, 1, 2, seen, rda, ra);
      checks++; if (rda !== 1'b0) begin failures++; $display("FAIL flush_rd_during got=%b exp=0", rda); end
      tick();
      checks++; if (data_ok !== 1'b0) begin failures++; $display("FAIL flush_no_hit got=%b exp=0", data_ok); end
      checks++; if (sdram_rd !== 1'b1) begin failures++; $display("FAIL flush_new_req got=%b exp=1", sdram_rd); end
      exp_q.push_back(16'hF1);
      serve({16'hF3, 16'hF2, 16'hF1, 16'hF0}, 0, -1, seen, rda, ra);
      tick();
      e = exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
      checks++; if (data_ok !== 1'b1 || dout !== e) begin failures++; $display("FAIL flush_refill ok=%b got=%h exp=%h", data_ok, dout, e); end
   endtask

   task automatic test_flush_vs_hit();
      bit seen; logic rda; logic [21:0] ra;
      flush = 1;
      tick();
      flush = 0;
      checks++; if (data_ok !== 1'b0) begin failures++; $display("FAIL flushhit_ok got=%b exp=0", data_ok); end
      tick();
      checks++; if (sdram_rd !== 1'b1) begin failures++; $display("FAIL flushhit_rereq got=%b exp=1", sdram_rd); end
      serve({16'hF3, 16'hF2, 16'hF1, 16'hF0}, 0, -1, seen, rda, ra);
      tick();
   endtask

   task automatic test_reset_wait();
      bit seen; logic rda; logic [21:0] ra; logic [15:0] e;
      addr = 22'h6001;
      tick();
      ack = 1; tick(); ack = 0;
      rst_n = 0;
      #2;
      checks++; if (sdram_rd !== 1'b0 || sdram_addr !== 22'h0) begin failures++; $display("FAIL rstwait_ctrl rd=%b addr=%h exp rd=0 addr=0", sdram_rd, sdram_addr); end
      cs = 0;
      tick();
      rst_n = 1;
      dst = 1; tick(); dst = 0;
      for (int j = 0; j < 4; j++) begin
         dok = 1; rdy = (j == 3); din = 16'h9990 + 16'(j); tick();
      end
      dok = 0; rdy = 0; din = 0;
      checks++; if (sdram_rd !== 1'b0) begin failures++; $display("FAIL rstwait_late_rd got=%b exp=0", sdram_rd); end
      cs = 1; addr = 22'h5001;
      tick();
      checks++; if (data_ok !== 1'b0) begin failures++; $display("FAIL rstwait_valid got=%b exp=0", data_ok); end
      checks++; if (sdram_rd !== 1'b1 || sdram_addr !== 22'h5000) begin failures++; $display("FAIL rstwait_fresh rd=%b addr=%h exp rd=1 addr=005000", sdram_rd, sdram_addr); end
      exp_q.push_back(16'h7701);
      serve({16'h7703, 16'h7702, 16'h7701, 16'h7700}, 0, -1, seen, rda, ra);
      tick();
      e = exp_q.size() > 0 ? exp_q.pop_front() : 16'hxxxx;
      checks++; if (data_ok !== 1'b1 || dout !== e) begin failures++; $display("FAIL rstwait_refill ok=%b got=%h exp=%h", data_ok, dout, e); end
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_hits();
      test_victim();
      test_dw32();
      test_flush_fill();
      test_flush_vs_hit();
      test_reset_wait();
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL queue_empty got=%0d exp=0", exp_q.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
